alu_writeback_stage: RTL and testbench

- Execute-to-writeback stage directly downstream of the ALU.
- Captures each ALU result (OutDest, OutFlags) with its destination register address.
- Holds the architectural flags register that drives the ALU InFlags input, and buffers results in a 2-entry skid buffer until the register file accepts the write.
- Provides a lookup port so operand fetch can bypass pending results.

---
 rtl/alu_writeback_stage_pkg.sv | 43 ++++
 rtl/alu_writeback_stage_if.sv | 46 ++++
 rtl/alu_writeback_stage_wb_skid_buffer.sv | 93 +++++++++
 rtl/alu_writeback_stage.sv | 57 +++++
 tb/tb_alu_writeback_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/alu_writeback_stage_pkg.sv
// ------------------------------------------------------------------
// alu_writeback_stage_pkg: shared widths, flag and buffer-entry types
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package alu_writeback_stage_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int REG_ADDR_WIDTH = 3;

  typedef struct packed {
    logic always_on;
    logic carry;
    logic no_carry;
    logic zero;
    logic not_zero;
    logic negative;
    logic positive;
    logic overflow;
  } flags_t;

  localparam flags_t FLAGS_RESET_VALUE = '{
    always_on: 1'b1,
    no_carry:  1'b1,
    not_zero:  1'b1,
    default:   1'b0
  };

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_writeback_stage_if.sv
// ------------------------------------------------------------------
// alu_writeback_stage_if: ALU result, register-file write and lookup signals
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface alu_writeback_stage_if;
  import alu_writeback_stage_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_write;
  logic                      in_flag_write;
  logic [REG_ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0]     in_result;
  flags_t                    in_flags;
  flags_t                    flags_out;
  logic                      rf_valid;
  logic                      rf_ready;
  logic [REG_ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0]     rf_data;
  logic [REG_ADDR_WIDTH-1:0] lookup_addr;
  logic                      lookup_hit;
  logic [DATA_WIDTH-1:0]     lookup_data;

  modport master (
    output in_valid, in_write, in_flag_write, in_addr, in_result, in_flags,
    input  in_ready, flags_out,
    input  rf_valid, rf_addr, rf_data,
    output rf_ready,
    output lookup_addr,
    input  lookup_hit, lookup_data
  );

  modport slave (
    input  in_valid, in_write, in_flag_write, in_addr, in_result, in_flags,
    output in_ready, flags_out,
    output rf_valid, rf_addr, rf_data,
    input  rf_ready,
    input  lookup_addr,
    output lookup_hit, lookup_data
  );

endinterface

`default_nettype wire

// File: rtl/alu_writeback_stage_wb_skid_buffer.sv
// ------------------------------------------------------------------
// wb_skid_buffer: 2-entry in-order write buffer with head output and lookup
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module wb_skid_buffer
  import alu_writeback_stage_pkg::*;
(
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  input  wire logic                      push,
  input  wire wb_entry_t                 push_entry,
  input  wire logic                      pop_ready,
  output logic                           ready,
  output logic                           head_valid,
  output wb_entry_t                      head,
  input  wire logic [REG_ADDR_WIDTH-1:0] lookup_addr,
  output logic                           lookup_hit,
  output logic [DATA_WIDTH-1:0]          lookup_data
);

  wb_state_e r_state;
  wb_state_e w_next_state;
  wb_entry_t r_entry0;
  wb_entry_t r_entry1;
  wb_entry_t w_next_entry0;
  wb_entry_t w_next_entry1;
  logic      w_pop;
  logic      w_hit0;
  logic      w_hit1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_entry0 <= '0;
      r_entry1 <= '0;
    end else begin
      r_state  <= w_next_state;
      r_entry0 <= w_next_entry0;
      r_entry1 <= w_next_entry1;
    end
  end

  assign w_pop = (r_state != EMPTY) && pop_ready;

  // entry0 is always the head; entry1 is only meaningful in TWO
  always_comb begin
    w_next_state  = r_state;
    w_next_entry0 = r_entry0;
    w_next_entry1 = r_entry1;
    case (r_state)
      EMPTY: begin
        if (push) begin
          w_next_state  = ONE;
          w_next_entry0 = push_entry;
        end
      end
      ONE: begin
        if (push && w_pop) begin
          w_next_entry0 = push_entry;
        end else if (push) begin
          w_next_state  = TWO;
          w_next_entry1 = push_entry;
        end else if (w_pop) begin
          w_next_state  = EMPTY;
        end
      end
      TWO: begin
        if (w_pop) begin
          w_next_state  = ONE;
          w_next_entry0 = r_entry1;
        end
      end
      default: begin
        w_next_state = EMPTY;
      end
    endcase
  end

  assign ready      = (r_state != TWO);
  assign head_valid = (r_state != EMPTY);
  assign head       = head_valid ? r_entry0 : '0;

  assign w_hit0      = head_valid && (r_entry0.addr == lookup_addr);
  assign w_hit1      = (r_state == TWO) && (r_entry1.addr == lookup_addr);
  assign lookup_hit  = w_hit0 || w_hit1;
  assign lookup_data = w_hit1 ? r_entry1.data :
                       w_hit0 ? r_entry0.data : '0;

endmodule

`default_nettype wire

// File: rtl/alu_writeback_stage.sv
// ------------------------------------------------------------------
// alu_writeback_stage: flags register, accept logic and write-back buffering
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu_writeback_stage
  import alu_writeback_stage_pkg::*;
(
  input  wire logic           clk,
  input  wire logic           rst_n,
  alu_writeback_stage_if.slave bus
);

  flags_t    r_flags;
  logic      w_ready;
  logic      w_accept;
  logic      w_push;
  wb_entry_t w_push_entry;
  logic      w_head_valid;
  wb_entry_t w_head;

  assign w_accept     = bus.in_valid && w_ready;
  assign w_push       = w_accept && bus.in_write;
  assign w_push_entry = '{addr: bus.in_addr, data: bus.in_result};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= FLAGS_RESET_VALUE;
    end else if (w_accept && bus.in_flag_write) begin
      r_flags <= bus.in_flags;
    end
  end

  wb_skid_buffer u_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (w_push),
    .push_entry  (w_push_entry),
    .pop_ready   (bus.rf_ready),
    .ready       (w_ready),
    .head_valid  (w_head_valid),
    .head        (w_head),
    .lookup_addr (bus.lookup_addr),
    .lookup_hit  (bus.lookup_hit),
    .lookup_data (bus.lookup_data)
  );

  assign bus.in_ready  = w_ready;
  assign bus.flags_out = r_flags;
  assign bus.rf_valid  = w_head_valid;
  assign bus.rf_addr   = w_head.addr;
  assign bus.rf_data   = w_head.data;

endmodule

`default_nettype wire

// File: tb/tb_alu_writeback_stage.sv
// ------------------------------------------------------------------
// tb_alu_writeback_stage: directed vector table plus randomized model check
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_alu_writeback_stage;
  import alu_writeback_stage_pkg::*;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic        fw;
    logic [2:0]  addr;
    logic [15:0] res;
    logic [7:0]  flags;
    logic        rdy;
    logic [2:0]  lk;
    logic        e_ready;
    logic        e_rfv;
    logic [2:0]  e_addr;
    logic [15:0] e_data;
    logic        e_hit;
    logic [15:0] e_ld;
    logic [7:0]  e_flags;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  alu_writeback_stage_if bus();

  alu_writeback_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n === 1'b1 && bus.in_valid === 1'b1)
      assert (bus.in_ready === 1'b1) else $error("protocol violation: in_valid while stage not ready");
  end

  // Reference model: pending writes in arrival order plus the flags word
  wb_entry_t q[$];
  flags_t    m_flags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic fw, input logic [2:0] a,
                       input logic [15:0] r, input logic [7:0] f, input logic rdy, input logic [2:0] lk);
    bus.in_valid      = v;
    bus.in_write      = w;
    bus.in_flag_write = fw;
    bus.in_addr       = a;
    bus.in_result     = r;
    bus.in_flags      = flags_t'(f);
    bus.rf_ready      = rdy;
    bus.lookup_addr   = lk;
  endtask

  task automatic cycle();
    bit can_accept;
    @(posedge clk);
    can_accept = (q.size() < 2);
    if (bus.in_valid && can_accept && bus.in_flag_write) m_flags = bus.in_flags;
    if (q.size() > 0 && bus.rf_ready) void'(q.pop_front());
    if (bus.in_valid && can_accept && bus.in_write) q.push_back('{addr: bus.in_addr, data: bus.in_result});
    @(negedge clk);
  endtask

  task automatic check_model();
    logic        hit;
    logic [15:0] ld;
    hit = 1'b0;
    ld  = '0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].addr == bus.lookup_addr) begin
        hit = 1'b1;
        ld  = q[i].data;
      end
    end
    check("rnd_in_ready", bus.in_ready, q.size() < 2);
    check("rnd_rf_valid", bus.rf_valid, q.size() > 0);
    check("rnd_rf_addr", bus.rf_addr, (q.size() > 0) ? q[0].addr : 3'd0);
    check("rnd_rf_data", bus.rf_data, (q.size() > 0) ? q[0].data : 16'd0);
    check("rnd_lookup_hit", bus.lookup_hit, hit);
    check("rnd_lookup_data", bus.lookup_data, ld);
    check("rnd_flags", bus.flags_out, m_flags);
  endtask

  vec_t   vecs[16];
  flags_t f_rst;
  flags_t f_z;
  flags_t f_c;

  initial begin
    f_rst = '0; f_rst.always_on = 1'b1; f_rst.no_carry = 1'b1; f_rst.not_zero = 1'b1;
    f_z   = '0; f_z.zero = 1'b1;
    f_c   = '0; f_c.carry = 1'b1;

    //          v  w  fw a  res       flags  rdy lk   rdy rfv a  data      hit ld        flags
    vecs[0]  = '{1, 1, 1, 3, 16'h1234, f_z,   1,  3,   1,  1,  3, 16'h1234, 1,  16'h1234, f_z};
    vecs[1]  = '{0, 0, 0, 0, 16'h0000, 8'h0,  1,  3,   1,  0,  0, 16'h0000, 0,  16'h0000, f_z};
    vecs[2]  = '{1, 1, 0, 1, 16'h00AA, 8'hFF, 0,  1,   1,  1,  1, 16'h00AA, 1,  16'h00AA, f_z};
    vecs[3]  = '{1, 1, 0, 2, 16'h00BB, 8'h0,  0,  2,   0,  1,  1, 16'h00AA, 1,  16'h00BB, f_z};
    vecs[4]  = '{0, 0, 0, 0, 16'h0000, 8'h0,  0,  1,   0,  1,  1, 16'h00AA, 1,  16'h00AA, f_z};
    vecs[5]  = '{0, 0, 0, 0, 16'h0000, 8'h0,  1,  1,   1,  1,  2, 16'h00BB, 0,  16'h0000, f_z};
    vecs[6]  = '{0, 0, 0, 0, 16'h0000, 8'h0,  1,  2,   1,  0,  0, 16'h0000, 0,  16'h0000, f_z};
    vecs[7]  = '{1, 1, 0, 5, 16'h0011, 8'h0,  0,  5,   1,  1,  5, 16'h0011, 1,  16'h0011, f_z};
    vecs[8]  = '{1, 1, 0, 5, 16'h0022, 8'h0,  0,  5,   0,  1,  5, 16'h0011, 1,  16'h0022, f_z};
    vecs[9]  = '{0, 0, 0, 0, 16'h0000, 8'h0,  0,  4,   0,  1,  5, 16'h0011, 0,  16'h0000, f_z};
    vecs[10] = '{0, 0, 0, 0, 16'h0000, 8'h0,  1,  5,   1,  1,  5, 16'h0022, 1,  16'h0022, f_z};
    vecs[11] = '{0, 0, 0, 0, 16'h0000, 8'h0,  1,  5,   1,  0,  0, 16'h0000, 0,  16'h0000, f_z};
    vecs[12] = '{1, 0, 1, 6, 16'hFFFF, f_c,   1,  6,   1,  0,  0, 16'h0000, 0,  16'h0000, f_c};
    vecs[13] = '{1, 1, 0, 7, 16'h0101, 8'h0,  0,  7,   1,  1,  7, 16'h0101, 1,  16'h0101, f_c};
    vecs[14] = '{1, 1, 0, 0, 16'h0202, 8'h0,  1,  7,   1,  1,  0, 16'h0202, 0,  16'h0000, f_c};
    vecs[15] = '{0, 0, 0, 0, 16'h0000, 8'h0,  1,  0,   1,  0,  0, 16'h0000, 0,  16'h0000, f_c};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 16'h0, 8'h0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_flags", bus.flags_out, f_rst);
    check("reset_rf_valid", bus.rf_valid, 1'b0);
    check("reset_rf_addr", bus.rf_addr, 3'd0);
    check("reset_rf_data", bus.rf_data, 16'd0);
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_lookup_hit", bus.lookup_hit, 1'b0);
    check("reset_lookup_data", bus.lookup_data, 16'd0);
    m_flags = f_rst;
    q.delete();
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].write, vecs[i].fw, vecs[i].addr, vecs[i].res,
            vecs[i].flags, vecs[i].rdy, vecs[i].lk);
      cycle();
      check($sformatf("vec%0d_in_ready", i), bus.in_ready, vecs[i].e_ready);
      check($sformatf("vec%0d_rf_valid", i), bus.rf_valid, vecs[i].e_rfv);
      check($sformatf("vec%0d_rf_addr", i), bus.rf_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_rf_data", i), bus.rf_data, vecs[i].e_data);
      check($sformatf("vec%0d_lookup_hit", i), bus.lookup_hit, vecs[i].e_hit);
      check($sformatf("vec%0d_lookup_data", i), bus.lookup_data, vecs[i].e_ld);
      check($sformatf("vec%0d_flags", i), bus.flags_out, vecs[i].e_flags);
    end

    for (int n = 0; n < 400; n++) begin
      drive((q.size() < 2) ? 1'($urandom_range(0, 1)) : 1'b0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom), 16'($urandom), 8'($urandom),
            1'($urandom_range(0, 2) != 0 ? 1 : 0) & 1'($urandom_range(0, 1)),
            3'($urandom));
      cycle();
      check_model();
    end

    // Asynchronous reset while a write is pending
    drive(0, 0, 0, 0, 16'h0, 8'h0, 1, 0);
    repeat (3) cycle();
    drive(1, 1, 1, 4, 16'h4444, 8'h55, 0, 4);
    cycle();
    check_model();
    drive(0, 0, 0, 0, 16'h0, 8'h0, 1, 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_flags", bus.flags_out, f_rst);
    check("async_reset_rf_valid", bus.rf_valid, 1'b0);
    check("async_reset_in_ready", bus.in_ready, 1'b1);
    check("async_reset_lookup_hit", bus.lookup_hit, 1'b0);
    q.delete();
    m_flags = f_rst;
    cycle();
    check("reset_hold_rf_valid", bus.rf_valid, 1'b0);
    rst_n = 1'b1;
    cycle();
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
